uart_tx_engine: RTL
===================

Name: uart_tx_engine

Overview:
- UART transmit serialiser sitting directly downstream of a sync FIFO.
- Pops bytes from the FIFO read port (rdata/empty/ren) and shifts them out LSB-first on a single TX line.
- Runtime-programmable bit period, optional parity, 1 or 2 stop bits.
- Supports back-to-back frames with no idle gap while the FIFO has data.

Parameters:
- W_DIV, 16, width of bit-period divider input.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  transmitter enable; sampled only at frame boundaries
- div  input  W_DIV  bit period minus one, in clk cycles (period = div+1)
- parity_en  input  1  1 = insert parity bit after data
- parity_odd  input  1  1 = odd parity, 0 = even; ignored if !parity_en
- stop2  input  1  1 = two stop bits, 0 = one
- fifo_rdata  input  8  FIFO head data, valid whenever !fifo_empty
- fifo_empty  input  1  FIFO empty flag
- fifo_ren  output  1  FIFO pop strobe, single-cycle
- tx  output  1  serial output, idle high
- busy  output  1  high while a frame is in progress

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE, tx=1, fifo_ren=0, busy=0.
  - Counters, shift register and latched config cleared.
- fifo_ren is combinational from registered state and fifo_empty.
  - Never asserted when fifo_empty=1.
  - At most one cycle per frame.
- Data capture: fifo_rdata is latched into an 8-bit shift register in the same cycle fifo_ren=1.
- Config latch: div, parity_en, parity_odd and stop2 are latched on that same fetch cycle. Changes mid-frame have no effect until the next frame.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If en && !fifo_empty: fifo_ren=1, capture, go to START next cycle.
- START: tx=0 for div+1 cycles, then DATA.
- DATA:
  - tx = shreg[0] for div+1 cycles per bit; shift right after each bit.
  - 8 bits, LSB first.
  - Then PARITY if parity_en, else STOP.
- PARITY:
  - tx = XOR of the 8 data bits, XOR parity_odd.
  - Lasts div+1 cycles, then STOP.
- STOP: tx=1 for (stop2 ? 2 : 1) × (div+1) cycles.
- Last cycle of STOP:
  - If en && !fifo_empty: fifo_ren=1, capture, go directly to START. No idle cycle between frames.
  - Otherwise go to IDLE.
- Bit timing:
  - A down-counter is loaded with latched div at each bit start and the bit ends when it reaches 0.
  - div=0 gives 1 clk per bit, which is legal.
  - Counter width W_DIV; no overflow possible.
- Frame length = (1 + 8 + parity_en + 1 + stop2) × (div+1) cycles.
- busy = (state != IDLE). It goes high the cycle after the fetch and stays high across back-to-back frames.
- en deasserted mid-frame: the current frame completes unchanged, then IDLE. No FIFO pop occurs after en=0 is seen at a boundary.
- fifo_empty rising mid-frame: no effect on the current frame.
- Boundary rule: FIFO data arriving during the last STOP cycle is accepted in that cycle.
- Formal:
  - assert !(fifo_ren && fifo_empty).
  - assert tx==1 whenever state==IDLE.
  - assert one fifo_ren per START entry.

Test Plan:
- div=3, 8N1, FIFO holds 0xA5, en=1 -> one fifo_ren pulse.
  - tx low for 4 clks, then 1,0,1,0,0,1,0,1 at 4 clks each, then high for 4 clks.
  - busy high for exactly 40 clks.
- FIFO holds 0x12,0x34, div=1, 8N1 -> fifo_ren pulses exactly 20 clks apart.
  - Second start bit begins the cycle after the first stop bit ends; 40 clks busy total with no idle gap.
- parity_en=1, div=0, data 0x07 -> parity bit 1 with even parity, 0 with odd; frame 11 clks.
- stop2=1, div=2, data 0x00 -> tx high for 6 clks after the last data bit; frame 33 clks.
- Change div from 3 to 7 mid-frame -> current frame keeps 4-clk bits; next frame uses 8-clk bits.
  - Drop en mid-frame with the FIFO non-empty -> frame completes, no further fifo_ren, tx stays 1.
- Assert rst_n low in the middle of the DATA state -> tx=1, busy=0, fifo_ren=0 immediately.
  - After release with the FIFO non-empty and en=1 -> a fresh frame starts with a new pop.

Source files
------------

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: FIFO-fed UART serialiser with programmable bit period, optional parity and 1/2 stop bits.
`timescale 1ns/1ps
module uart_tx_engine #(
  parameter int W_DIV = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [W_DIV-1:0] div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  input  logic [7:0]       fifo_rdata,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  output logic             tx,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t           state;
  logic [W_DIV-1:0] cnt, div_l;
  logic [7:0]       shreg;
  logic [2:0]       bit_idx;
  logic             stop_idx, par_en_l, stop2_l, par_bit, armed;
  logic             last, fetch;
  assign last = cnt == '0;
  // armed keeps fifo_ren low while reset is held and for the first cycle after release
  assign fetch = armed && en && !fifo_empty &&
                 (state == IDLE || (state == STOP && last && (stop_idx || !stop2_l)));
  assign fifo_ren = fetch;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      cnt      <= '0;
      div_l    <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_en_l <= 1'b0;
      stop2_l  <= 1'b0;
      par_bit  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (fetch) begin
        state    <= START;
        tx       <= 1'b0;
        cnt      <= div;
        div_l    <= div;
        shreg    <= fifo_rdata;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        par_en_l <= parity_en;
        stop2_l  <= stop2;
        par_bit  <= ^fifo_rdata ^ parity_odd;
      end else begin
        case (state)
          IDLE: tx <= 1'b1;
          START: begin
            cnt <= last ? div_l : cnt - 1'b1;
            if (last) begin
              state <= DATA;
              tx    <= shreg[0];
            end
          end
          DATA: begin
            cnt <= last ? div_l : cnt - 1'b1;
            if (last) begin
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
              state   <= bit_idx == 3'd7 ? (par_en_l ? PARITY : STOP) : DATA;
              tx      <= bit_idx == 3'd7 ? (par_en_l ? par_bit : 1'b1) : shreg[1];
            end
          end
          PARITY: begin
            cnt <= last ? div_l : cnt - 1'b1;
            if (last) begin
              state <= STOP;
              tx    <= 1'b1;
            end
          end
          STOP: begin
            cnt <= last ? div_l : cnt - 1'b1;
            if (last) begin
              stop_idx <= 1'b1;
              state    <= (stop2_l && !stop_idx) ? STOP : IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  a_ren_not_empty: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_ren && fifo_empty));
  a_idle_tx_high:  assert property (@(posedge clk) disable iff (!rst_n) state == IDLE |-> tx);
  a_ren_to_start:  assert property (@(posedge clk) disable iff (!rst_n) fifo_ren |=> state == START);
  a_start_has_ren: assert property (@(posedge clk) disable iff (!rst_n)
                                    (state == START && $past(state) != START) |-> $past(fifo_ren));
endmodule
